ex_muldiv_sequencer: RTL and testbench



---
 rtl/ex_muldiv_sequencer_if.sv | 26 ++
 rtl/ex_muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide sequencer.
interface ex_muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_flush;
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            o_stall;
    logic            o_busy;
    logic            o_result_valid;
    logic [XLEN-1:0] o_result;

    // Pipeline side: drives the instruction, receives stall and result.
    modport master (
        output i_flush, i_start, i_funct3, i_op_a, i_op_b,
        input  o_stall, o_busy, o_result_valid, o_result
    );

    // Sequencer side.
    modport slave (
        input  i_flush, i_start, i_funct3, i_op_a, i_op_b,
        output o_stall, o_busy, o_result_valid, o_result
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit sitting beside the EX-stage ALU.
// One shared pair of XLEN registers holds {upper, lower} of the product or
// {remainder, quotient} of the division; one iteration runs per cycle.
module ex_muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_muldiv_sequencer_if.slave bif
);

    localparam logic [2:0]       F3_MUL   = 3'b000;
    localparam logic [2:0]       F3_MULHU = 3'b011;
    localparam logic [2:0]       F3_DIVU  = 3'b101;
    localparam logic [2:0]       F3_REMU  = 3'b111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_result_valid;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_acc;     // product upper half / partial remainder
    logic [XLEN-1:0]   r_lo;      // multiplier -> product lower half / dividend -> quotient
    logic [XLEN-1:0]   r_mcand;   // multiplicand or divisor
    logic              r_is_div;
    logic              r_sel_hi;  // MULHU/REMU take r_acc, MUL/DIVU take r_lo

    logic              w_legal;
    logic              w_accept;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_acc_next;
    logic [XLEN-1:0]   w_lo_next;

    // Decode: only the four supported M-type ops are accepted.
    always_comb begin
        w_legal  = (bif.i_funct3 == F3_MUL)  || (bif.i_funct3 == F3_MULHU) ||
                   (bif.i_funct3 == F3_DIVU) || (bif.i_funct3 == F3_REMU);
        w_accept = bif.i_start & w_legal;
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        w_addend = r_lo[0] ? r_mcand : '0;
        w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
        w_shift  = {r_acc, r_lo[XLEN-1]};
        w_ge     = (w_shift >= {1'b0, r_mcand});
        // A successful trial leaves a value below the divisor, so the low bits suffice.
        w_diff   = w_shift[XLEN-1:0] - r_mcand;
        if (r_is_div) begin
            w_acc_next = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_next  = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_acc_next = w_sum[XLEN:1];
            w_lo_next  = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Stall the front of the pipe while accepting or iterating; a flush releases it.
    assign bif.o_stall        = ~bif.i_flush &
                                (((r_state == S_IDLE) & w_accept) | (r_state == S_BUSY));
    assign bif.o_busy         = r_busy;
    assign bif.o_result_valid = r_result_valid;
    assign bif.o_result       = r_result;

    // Sequencer FSM and datapath registers; reset beats flush beats start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_acc          <= '0;
            r_lo           <= '0;
            r_mcand        <= '0;
            r_is_div       <= 1'b0;
            r_sel_hi       <= 1'b0;
        end else if (bif.i_flush) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result_valid <= 1'b0;
                    if (w_accept) begin
                        r_is_div <= bif.i_funct3[2];
                        r_sel_hi <= bif.i_funct3[1];
                        r_acc    <= '0;
                        r_lo     <= bif.i_funct3[2] ? bif.i_op_a : bif.i_op_b;
                        r_mcand  <= bif.i_funct3[2] ? bif.i_op_b : bif.i_op_a;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result       <= r_sel_hi ? w_acc_next : w_lo_next;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start here belongs to the finishing instruction, so it is ignored.
                    r_result_valid <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: per-cycle comparison against an op-level
// reference model plus directed operations with literal expected results.
module tb_ex_muldiv_sequencer;

    localparam int unsigned XLEN = 32;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   chk_en;

    ex_muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

    ex_muldiv_sequencer #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic bit m_legal(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b011) || (f == 3'b101) || (f == 3'b111);
    endfunction

    function automatic logic [31:0] m_calc(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (f)
            3'b000:  return p[31:0];
            3'b011:  return p[63:32];
            3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Op-level model: idle / busy for XLEN cycles / one result cycle.
    int          m_phase;
    int          m_left;
    bit          m_rv;
    logic [31:0] m_res;
    logic [31:0] m_exp;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_left  <= 0;
            m_rv    <= 1'b0;
            m_res   <= '0;
        end else if (bus.i_flush) begin
            m_phase <= 0;
            m_rv    <= 1'b0;
        end else if (m_phase == 0) begin
            m_rv <= 1'b0;
            if (bus.i_start && m_legal(bus.i_funct3)) begin
                m_exp   <= m_calc(bus.i_funct3, bus.i_op_a, bus.i_op_b);
                m_left  <= XLEN;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2;
                m_rv    <= 1'b1;
                m_res   <= m_exp;
            end
        end else begin
            m_rv    <= 1'b0;
            m_phase <= 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 64'(bus.o_stall),
                  64'(!bus.i_flush && ((m_phase == 0 && bus.i_start && m_legal(bus.i_funct3))
                                       || m_phase == 1)));
            check("busy", 64'(bus.o_busy), 64'(m_phase == 1));
            check("result_valid", 64'(bus.o_result_valid), 64'(m_rv));
            check("result", 64'(bus.o_result), 64'(m_res));
        end
    end

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.i_start  = 1'b1;
        bus.i_funct3 = f3;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
    endtask

    // Wait (bounded) for the result pulse; returns whether it was seen.
    task automatic wait_valid(output bit seen, inout int nst);
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.o_stall) nst = nst + 1;
            if (bus.o_result_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int s;
        int nst;
        bit seen;
        @(posedge clk); #1;
        drive_start(f3, a, b);
        s = cyc;
        @(negedge clk);
        nst = bus.o_stall ? 1 : 0;
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        bus.i_op_a   = $urandom;
        bus.i_op_b   = $urandom;
        bus.i_funct3 = 3'($urandom);
        wait_valid(seen, nst);
        check({nm, " seen"}, 64'(seen), 64'd1);
        check({nm, " latency"}, 64'(cyc - s), 64'd33);
        check({nm, " stall cycles"}, 64'(nst), 64'd33);
        check({nm, " value"}, 64'(bus.o_result), 64'(exp));
    endtask

    initial begin
        int  s;
        int  nst;
        int  pulses;
        bit  seen;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        chk_en       = 1'b0;
        reset        = 1'b1;
        bus.i_flush  = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_funct3 = 3'b000;
        bus.i_op_a   = '0;
        bus.i_op_b   = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(bus.o_busy), 64'd0);
        check("reset result_valid", 64'(bus.o_result_valid), 64'd0);
        check("reset result", 64'(bus.o_result), 64'd0);
        check("reset stall", 64'(bus.o_stall), 64'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed ops with hand-computed results.
        run_op("MUL 7x6", 3'b000, 32'd7, 32'd6, 32'd42);
        run_op("MULHU ff*ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("MUL ff*ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("REMU 100%7", 3'b111, 32'd100, 32'd7, 32'd2);
        run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("REMU 5%0", 3'b111, 32'd5, 32'd0, 32'd5);
        run_op("MULHU 0x80000000*4", 3'b011, 32'h8000_0000, 32'd4, 32'd2);

        // Flush at BUSY iteration 10.
        @(posedge clk); #1;
        drive_start(3'b101, 32'd1000, 32'd3);
        s = cyc;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        while (cyc < s + 11) begin
            @(posedge clk); #1;
        end
        bus.i_flush = 1'b1;
        @(negedge clk);
        check("flush stall", 64'(bus.o_stall), 64'd0);
        check("flush still busy", 64'(bus.o_busy), 64'd1);
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("after flush busy", 64'(bus.o_busy), 64'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_result_valid) pulses++;
        end
        check("flush no pulse", 64'(pulses), 64'd0);
        run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3);

        // Back-to-back: start held through DONE, then a new op right after.
        @(posedge clk); #1;
        drive_start(3'b000, 32'd3, 32'd3);
        s = cyc;
        nst = 0;
        wait_valid(seen, nst);
        check("b2b first latency", 64'(cyc - s), 64'd33);
        check("b2b first value", 64'(bus.o_result), 64'd9);
        @(posedge clk); #1;
        drive_start(3'b000, 32'd4, 32'd4);
        s = cyc;
        @(negedge clk);
        check("b2b idle result_valid", 64'(bus.o_result_valid), 64'd0);
        check("b2b accept stall", 64'(bus.o_stall), 64'd1);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        wait_valid(seen, nst);
        check("b2b second seen", 64'(seen), 64'd1);
        check("b2b second latency", 64'(cyc - s), 64'd33);
        check("b2b second value", 64'(bus.o_result), 64'd16);

        // Reset mid-BUSY with start asserted.
        @(posedge clk); #1;
        drive_start(3'b000, 32'd5, 32'd5);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_start(3'b000, 32'd2, 32'd2);
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("midreset busy", 64'(bus.o_busy), 64'd0);
        check("midreset result_valid", 64'(bus.o_result_valid), 64'd0);
        check("midreset result", 64'(bus.o_result), 64'd0);
        check("midreset stall", 64'(bus.o_stall), 64'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_result_valid) pulses++;
        end
        check("midreset no pulse", 64'(pulses), 64'd0);

        // Illegal funct3.
        @(posedge clk); #1;
        drive_start(3'b001, 32'd6, 32'd7);
        @(negedge clk);
        check("illegal stall", 64'(bus.o_stall), 64'd0);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.o_result_valid || bus.o_busy) pulses++;
        end
        check("illegal no activity", 64'(pulses), 64'd0);

        run_op("REMU ffffffff%10", 3'b111, 32'hFFFF_FFFF, 32'd10, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
